// File: rtl/aes_spi_sequencer.sv
// aes_spi_sequencer: expands one host encryption request into the
// key / message / readback frame protocol of the SPI-attached AES core,
// with settle gaps between frames, key reuse and a per-frame timeout.
module aes_spi_sequencer #(
   parameter int unsigned GAP_CYCLES     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req,
   output logic           ready,
   input  logic [1:0]     key_mode,
   input  logic           reuse_key,
   input  logic [255:0]   key,
   input  logic [127:0]   msg,
   output logic [127:0]   ct,
   output logic           ct_valid,
   output logic           err,
   output logic           key_loaded,
   output logic           spi_start,
   output logic [0:257]   spi_tx,
   input  logic [127:0]   spi_rx,
   input  logic           spi_done
);

   typedef enum logic [3:0] {
      IDLE,
      KEY_START,
      KEY_WAIT,
      KEY_GAP,
      MSG_START,
      MSG_WAIT,
      MSG_GAP,
      RD_START,
      RD_WAIT,
      DONE,
      ERR
   } state_e;

   localparam logic [1:0]  MODE_128 = 2'b00;
   localparam logic [1:0]  MODE_192 = 2'b01;
   localparam logic [1:0]  MODE_ILL = 2'b11;

   // Last counter value of a gap / of a wait before timing out.
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

   // Key frame: mode prefix then the key zero-extended to 256 bits; bits
   // above the key length are dropped so stale upper host bits never leak.
   function automatic logic [0:257] key_frame(input logic [1:0]   mode,
                                              input logic [255:0] k);
      logic [0:257] f;
      case (mode)
         MODE_128: f = {mode, 128'b0, k[127:0]};
         MODE_192: f = {mode, 64'b0, k[191:0]};
         default:  f = {mode, k};
      endcase
      return f;
   endfunction

   state_e         state_q, state_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [127:0]   msg_lat_q, msg_lat_d;
   logic [1:0]     mode_lat_q, mode_lat_d;
   logic [1:0]     loaded_mode_q, loaded_mode_d;
   logic           key_loaded_q, key_loaded_d;
   logic [127:0]   ct_q, ct_d;
   logic           ct_valid_q, ct_valid_d;
   logic           err_q, err_d;
   logic           ready_q, ready_d;
   logic           spi_start_q, spi_start_d;
   logic [0:257]   spi_tx_q, spi_tx_d;

   // Next-state, counters, latched request and registered output values.
   always_comb begin
      // NOTE: every variable gets a default first, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      msg_lat_d     = msg_lat_q;
      mode_lat_d    = mode_lat_q;
      loaded_mode_d = loaded_mode_q;
      key_loaded_d  = key_loaded_q;
      ct_d          = ct_q;
      spi_tx_d      = spi_tx_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               msg_lat_d  = msg;
               mode_lat_d = key_mode;
               if (key_mode == MODE_ILL) begin
                  state_d = ERR;
               end else if (reuse_key && key_loaded_q && (key_mode == loaded_mode_q)) begin
                  state_d = MSG_START;
               end else begin
                  state_d = KEY_START;
               end
            end
         end
         KEY_START: state_d = KEY_WAIT;
         KEY_WAIT: begin
            // A done on the final timeout cycle still wins over the timeout.
            if (spi_done) begin
               key_loaded_d  = 1'b1;
               loaded_mode_d = mode_lat_q;
               state_d       = HAS_GAP ? KEY_GAP : MSG_START;
            end else if (cnt_q == TMO_LAST) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         KEY_GAP: begin
            if (cnt_q == GAP_LAST) state_d = MSG_START;
            else                   cnt_d   = cnt_q + 16'd1;
         end
         MSG_START: state_d = MSG_WAIT;
         MSG_WAIT: begin
            if (spi_done) begin
               state_d = HAS_GAP ? MSG_GAP : RD_START;
            end else if (cnt_q == TMO_LAST) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         MSG_GAP: begin
            if (cnt_q == GAP_LAST) state_d = RD_START;
            else                   cnt_d   = cnt_q + 16'd1;
         end
         RD_START: state_d = RD_WAIT;
         RD_WAIT: begin
            if (spi_done) begin
               ct_d    = spi_rx;
               state_d = DONE;
            end else if (cnt_q == TMO_LAST) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Any state change restarts the shared gap/timeout counter.
      if (state_d != state_q) begin
         cnt_d = '0;
      end

      // Frames are loaded once on entry to a START state and then held.
      // The key frame is built straight from the request, since KEY_START
      // is only ever entered from the accept cycle.
      if (state_d != state_q) begin
         case (state_d)
            KEY_START: spi_tx_d = key_frame(mode_lat_d, key);
            MSG_START: spi_tx_d = {130'b0, msg_lat_d};
            RD_START:  spi_tx_d = '0;
            default:   ;
         endcase
      end

      // An error leaves the core's key state unknown, so force a reload.
      if (state_d == ERR) begin
         key_loaded_d = 1'b0;
      end

      ready_d     = (state_d == IDLE);
      spi_start_d = (state_d == KEY_START) || (state_d == MSG_START) ||
                    (state_d == RD_START);
      ct_valid_d  = (state_d == DONE);
      err_d       = (state_d == ERR);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         msg_lat_q     <= '0;
         mode_lat_q    <= '0;
         loaded_mode_q <= '0;
         key_loaded_q  <= 1'b0;
         ct_q          <= '0;
         ct_valid_q    <= 1'b0;
         err_q         <= 1'b0;
         ready_q       <= 1'b1;
         spi_start_q   <= 1'b0;
         spi_tx_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         msg_lat_q     <= msg_lat_d;
         mode_lat_q    <= mode_lat_d;
         loaded_mode_q <= loaded_mode_d;
         key_loaded_q  <= key_loaded_d;
         ct_q          <= ct_d;
         ct_valid_q    <= ct_valid_d;
         err_q         <= err_d;
         ready_q       <= ready_d;
         spi_start_q   <= spi_start_d;
         spi_tx_q      <= spi_tx_d;
      end
   end

   assign ready      = ready_q;
   assign ct         = ct_q;
   assign ct_valid   = ct_valid_q;
   assign err        = err_q;
   assign key_loaded = key_loaded_q;
   assign spi_start  = spi_start_q;
   assign spi_tx     = spi_tx_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: behavioural SPI/AES responder, directed
// requests with hand-computed timing, and a scoreboard-driven monitor.
module tb_aes_spi_sequencer;

   localparam int GAP = 5;
   localparam int TMO = 100;

   localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] K128X = {128'hffffffffffffffffffffffffffffffff, K128};
   localparam logic [255:0] K192X = {64'hffffffffffffffff, K192};
   localparam logic [127:0] MSG   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic         reuse_key = 1'b0;
   logic [1:0]   key_mode = 2'b00;
   logic [255:0] key = '0;
   logic [127:0] msg = '0;
   logic [127:0] spi_rx = '0;
   logic         spi_done = 1'b0;
   logic         ready, ct_valid, err, key_loaded, spi_start;
   logic [127:0] ct;
   logic [0:257] spi_tx;

   aes_spi_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .key_mode(key_mode),
      .reuse_key(reuse_key), .key(key), .msg(msg), .ct(ct), .ct_valid(ct_valid),
      .err(err), .key_loaded(key_loaded), .spi_start(spi_start), .spi_tx(spi_tx),
      .spi_rx(spi_rx), .spi_done(spi_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int           id;
      bit           is_err;
      logic [127:0] ct;
      int           done_at;
      int           n_st;
      int           s0, s1, s2;
      int           t0;
      logic [1:0]   mode;
      bit           kl;
   } exp_t;

   exp_t sb[$];

   function automatic int st_exp(input exp_t e, input int i);
      if (i == 0) return e.s0;
      if (i == 1) return e.s1;
      return e.s2;
   endfunction

   // ---------------- behavioural SPI_Main + AES_Encrypt ----------------
   // Frames arrive in protocol order: the frame before a message frame is a
   // key frame; an all-zero frame reads back the encryption of the pair.
   int           spi_d = 10;   // cycles spi_start -> spi_done; 0 = never
   logic [0:257] frame;
   logic [0:257] pend_frame = '0;
   logic [0:257] key_reg = '0;
   bit           pend_v = 1'b0;

   function automatic logic [127:0] aes_lookup(input logic [0:257] kf, input logic [0:257] mf);
      if (mf != {130'b0, MSG})               return 128'hbad0;
      if (kf == {2'b00, 128'b0, K128})       return CT128;
      if (kf == {2'b01, 64'b0, K192})        return CT192;
      if (kf == {2'b10, K256})               return CT256;
      return 128'hbad1;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && spi_start) begin
            frame = spi_tx;
            if (spi_d > 0) begin
               repeat (spi_d - 1) @(posedge clk);
               #1;
               if (frame == '0) begin
                  spi_rx = aes_lookup(key_reg, pend_frame);
                  pend_v = 1'b0;
               end else begin
                  if (pend_v) key_reg = pend_frame;
                  pend_frame = frame;
                  pend_v     = 1'b1;
                  spi_rx     = 128'hdead;
               end
               spi_done = 1'b1;
               @(posedge clk);
               #1 spi_done = 1'b0;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int n_seen = 0;
   int st_seen[3];
   bit chk_ready = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            n_seen    = 0;
            chk_ready = 1'b0;
         end else begin
            if (chk_ready) begin
               check("ready_after_completion", ready, 1);
               chk_ready = 1'b0;
            end
            if (spi_start && sb.size() > 0) begin
               if (n_seen == 0 && sb[0].n_st == 3)
                  check($sformatf("t%0d.key_frame_mode", sb[0].id), spi_tx[0:1], sb[0].mode);
               if (n_seen < 3) st_seen[n_seen] = cyc - sb[0].t0;
               n_seen++;
            end
            if (ct_valid || err) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_completion: ct_valid=%0b err=%0b, expected no completion",
                           ct_valid, err);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("t%0d.err", e.id), err, e.is_err);
                  check($sformatf("t%0d.ct_valid", e.id), ct_valid, !e.is_err);
                  if (!e.is_err) check($sformatf("t%0d.ct", e.id), ct, e.ct);
                  check($sformatf("t%0d.latency", e.id), cyc - e.t0, e.done_at);
                  check($sformatf("t%0d.start_count", e.id), n_seen, e.n_st);
                  for (int i = 0; i < e.n_st && i < 3; i++)
                     check($sformatf("t%0d.start%0d_cycle", e.id, i), st_seen[i], st_exp(e, i));
                  check($sformatf("t%0d.key_loaded", e.id), key_loaded, e.kl);
               end
               n_seen    = 0;
               chk_ready = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run(input int id, input logic [1:0] m, input bit reuse, input logic [255:0] k,
                      input int d, input bit is_err, input logic [127:0] ect, input int done_at,
                      input int n_st, input int s0, input int s1, input int s2, input bit kl);
      exp_t e;
      int   budget;
      spi_d = d;
      @(posedge clk);
      #1;
      budget = 0;
      while (!ready && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      key_mode  = m;
      reuse_key = reuse;
      key       = k;
      msg       = MSG;
      req       = 1'b1;
      e = '{id: id, is_err: is_err, ct: ect, done_at: done_at, n_st: n_st,
            s0: s0, s1: s1, s2: s2, t0: cyc, mode: m, kl: kl};
      sb.push_back(e);
      @(posedge clk);
      #1;
      req = 1'b0;
      key = ~k;     // the request must have been captured on accept
      msg = ~MSG;
      budget = 0;
      while (sb.size() > 0 && budget < 1000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL t%0d.completion: none within %0d cycles, expected at cycle %0d", id, budget, done_at);
         sb.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".ready"}, ready, 1);
      check({tag, ".spi_start"}, spi_start, 0);
      check({tag, ".spi_tx_nonzero"}, |spi_tx, 0);
      check({tag, ".ct"}, ct, 0);
      check({tag, ".ct_valid"}, ct_valid, 0);
      check({tag, ".err"}, err, 0);
      check({tag, ".key_loaded"}, key_loaded, 0);
   endtask

   initial begin
      int t0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      //   id mode   reuse key    D    err ct     done starts s0 s1  s2  kl
      run(1, 2'b11, 0, K128X, 10, 1, '0,     1,   0,     0, 0,   0,  0);  // illegal mode
      run(2, 2'b00, 0, K128X, 10, 0, CT128, 44,  3,     1, 17,  33, 1);  // AES-128 full
      run(3, 2'b00, 1, K128X, 10, 0, CT128, 28,  2,     1, 17,  0,  1);  // reuse key
      run(4, 2'b10, 1, K256,  10, 0, CT256, 44,  3,     1, 17,  33, 1);  // reuse, new mode
      run(5, 2'b01, 0, K192X, 3,  0, CT192, 23,  3,     1, 10,  19, 1);  // AES-192, D=3
      run(6, 2'b00, 0, K128X, 100, 0, CT128, 314, 3,    1, 107, 213, 1); // done on last wait cycle
      run(7, 2'b00, 0, K128X, 0,  1, '0,     102, 1,    1, 0,   0,  0);  // timeout
      run(8, 2'b00, 1, K128X, 10, 0, CT128, 44,  3,     1, 17,  33, 1);  // reload after error

      // Reset while the message frame is in flight.
      spi_d = 10;
      @(posedge clk);
      #1;
      key_mode  = 2'b10;
      reuse_key = 1'b0;
      key       = K256;
      msg       = MSG;
      req       = 1'b1;
      t0        = cyc;
      @(posedge clk);
      #1;
      req = 1'b0;
      while (cyc != t0 + 20) begin
         @(posedge clk);
         #1;
      end
      check("mid.busy_before_reset", ready, 0);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      #6 rst_n = 1'b1;
      repeat (30) @(posedge clk);

      run(9, 2'b10, 1, K256, 10, 0, CT256, 44, 3, 1, 17, 33, 1);  // reload after reset

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_spi_sequencer.md
# aes_spi_sequencer

Host-side controller that runs a full AES encryption through the SPI-attached `AES_Encrypt` core by sequencing `SPI_Main`. One host request is expanded into the three-frame protocol: key frame with mode prefix, message frame, then an all-zero readback frame. The block inserts settle gaps between frames, skips the key frame when the loaded key is reused, and flags an error when a frame never completes. It sits between the host logic and `SPI_Main`.

## Interface
- GAP_CYCLES, 64, idle cycles after each non-final frame's `spi_done` before the next `spi_start` (0 = no gap); must be < 65536
- TIMEOUT_CYCLES, 4096, maximum WAIT-state cycles without `spi_done` before an error; 1..65535
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  encryption request; accepted only when `ready`=1
- ready  out  1  high only in IDLE
- key_mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
- reuse_key  in  1  skip key frame if a key with the same mode is loaded
- key  in  256  key, right-justified; unused upper bits ignored
- msg  in  128  plaintext
- ct  out  128  ciphertext; holds last value
- ct_valid  out  1  one-cycle pulse when `ct` updates
- err  out  1  one-cycle pulse on illegal mode or timeout
- key_loaded  out  1  a key was successfully sent since reset/error
- spi_start  out  1  one-cycle start pulse to `SPI_Main`
- spi_tx  out  258  frame to `SPI_Main`, bit 0 = MSB
- spi_rx  in  128  `SPI_Main` receive word
- spi_done  in  1  `SPI_Main` frame-complete

## Operation
- States: IDLE, KEY_START, KEY_WAIT, KEY_GAP, MSG_START, MSG_WAIT, MSG_GAP, RD_START, RD_WAIT, DONE, ERR.
- Accept (IDLE, `req`=1): latch key, key_mode, msg, reuse_key.
  - mode 11 -> ERR. No `spi_start` is issued.
  - reuse_key=1, key_loaded=1 and latched mode equals the loaded mode -> MSG_START.
  - Otherwise -> KEY_START.
- Frames are registered, loaded on entry to *_START and held through *_WAIT:
  - Key frame: `spi_tx[0:1]`=mode, `spi_tx[2:257]`=key zero-extended to 256 bits. For 128/192-bit keys only the low 128/192 bits are used.
  - Message frame: 130 zero bits, then msg in `spi_tx[130:257]`.
  - Readback frame: all zeros.
- *_START: `spi_start`=1 for exactly that cycle, then -> *_WAIT.
- *_WAIT: `spi_done`=1 -> GAP state (or directly to the next START if GAP_CYCLES=0).
  - RD_WAIT instead captures `spi_rx` into `ct` and goes to DONE.
  - Timeout counter reaches TIMEOUT_CYCLES with no done -> ERR.
- KEY_WAIT done: set `key_loaded`=1 and record the loaded mode.
- GAP: count GAP_CYCLES cycles, then -> next START. KEY_GAP goes to MSG_START; MSG_GAP goes to RD_START.
- DONE: `ct_valid`=1 -> IDLE.
- ERR: `err`=1, clear `key_loaded` -> IDLE.
- `req` outside IDLE is ignored. `spi_done` outside *_WAIT is ignored.
- Counters are 16 bits and cleared on every state entry.

## Timing
- Reset values: state IDLE, ready=1, spi_start=0, spi_tx=0, ct=0, ct_valid=0, err=0, key_loaded=0.
- All outputs are registered.
- Accept cycle = 0. Let D = cycles from `spi_start` to `spi_done` (D≥1), G = GAP_CYCLES.
- Full sequence:
  - `spi_start` high in cycles 1, 2+D+G and 3+2D+2G.
  - `ct`/`ct_valid` valid in cycle 4+3D+2G.
  - `ready`=1 again in cycle 5+3D+2G.
- Reused key:
  - `spi_start` high in cycles 1 and 2+D+G.
  - `ct_valid` in cycle 3+2D+G.
- Illegal mode: `err` in cycle 1, `ready` in cycle 2.
- Timeout: with `spi_start` in cycle c and no done, `err` is high in cycle c+TIMEOUT_CYCLES+1.
- `spi_done` coincident with the last timeout cycle counts as done; no error is raised.
- Reset mid-sequence: immediate return to reset values. The SPI frame in flight is not aborted by this block, and the next request always reloads the key.

## Test plan
- AES-128 end to end with `SPI_Main`+`AES_Encrypt`, GAP_CYCLES=64.
  - Stimulus: key 000102…0f, mode 00, msg 00112233445566778899aabbccddeeff.
  - Required: ct=69c4e0d86a7b0430d8cdb78070b4c55a, one `ct_valid` pulse, key frame bits[0:1]=00.
- AES-192 (key 000102…17) and AES-256 (key 000102…1f), same msg.
  - Required: ct=dda97ca4864cdfe06eaf70a0ec0d7191 and ct=8ea2b7ca516745bfeafc49904b496089; `spi_tx[0:1]`=01 and 10 respectively.
- Reuse path, after the AES-128 run.
  - Stimulus: reuse_key=1, same mode.
  - Required: exactly two `spi_start` pulses, identical ct.
  - Then reuse_key=1 with mode 10: three pulses (key reloaded).
- Illegal mode 11.
  - Required: `err` pulse in cycle 1, zero `spi_start`, `key_loaded` unchanged=0 after reset.
- Timeout with a behavioural SPI model that never asserts done, TIMEOUT_CYCLES=100.
  - Required: `err` exactly 101 cycles after `spi_start`, `key_loaded`=0, `ready`=1 next cycle.
  - Also: done on the 100th WAIT cycle produces no error.
- Latency check with a model giving D=10 and G=5.
  - Required: `spi_start` at cycles 1/17/33, `ct_valid` at cycle 44.
  - Reset asserted in cycle 20 forces all outputs to reset values immediately.
